// File: rtl/obi_mem_arbiter_pkg.sv
// Shared types and helpers for the fetch/LSU memory arbiter.
package obi_mem_arbiter_pkg;

  // Requester identity, also the element type held in the response ID FIFO.
  typedef enum logic {
    ARB_INSTR = 1'b0,
    ARB_DATA  = 1'b1
  } arb_id_e;

  // Round-robin pick for an unlocked cycle: a lone requester wins; on
  // contention the one that was not granted last wins; idle selects fetch.
  function automatic arb_id_e arb_pick(input logic i_req, input logic d_req,
                                       input arb_id_e last);
    arb_id_e pick;
    if (i_req && d_req) begin
      pick = (last == ARB_INSTR) ? ARB_DATA : ARB_INSTR;
    end else if (d_req) begin
      pick = ARB_DATA;
    end else begin
      pick = ARB_INSTR;
    end
    return pick;
  endfunction

endpackage

// File: rtl/obi_mem_arbiter_if.sv
// Request/response bundle of the core memory handshake (proc_req/mem_rdy/valid).
interface obi_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          proc_req;
  logic          mem_rdy;
  logic [AW-1:0] addr;
  logic          we;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          valid;

  // Side that issues requests (core port, or the arbiter toward memory).
  modport master (
    output proc_req, addr, we, wdata,
    input  mem_rdy, rdata, valid
  );

  // Side that accepts requests and returns responses.
  modport slave (
    input  proc_req, addr, we, wdata,
    output mem_rdy, rdata, valid
  );
endinterface

// File: rtl/obi_mem_arbiter_id_fifo.sv
// In-order FIFO of requester IDs; the head names the owner of the next response.
module arb_id_fifo
  import obi_mem_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    push_i,
  input  logic    pop_i,
  input  arb_id_e push_id_i,
  output arb_id_e head_id_o,
  output logic    full_o,
  output logic    empty_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  arb_id_e       id_mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  // Head is read combinationally so the response can be routed in the same cycle.
  assign head_id_o = id_mem_q[rd_ptr_q];

  // Pointer step that wraps at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // ID storage: written on push only, contents need no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) id_mem_q[wr_ptr_q] <= push_id_i;
  end

  // Pointers and occupancy; simultaneous push/pop leaves the count unchanged.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/obi_mem_arbiter.sv
// Two-to-one round-robin arbiter with request locking in front of a shared
// single-port memory; responses are steered back through an ID FIFO.
module obi_mem_arbiter
  import obi_mem_arbiter_pkg::*;
#(
  parameter int MAX_OUTST = 2,
  parameter int AW        = 32,
  parameter int DW        = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  obi_mem_arbiter_if.slave        instr_bus,
  obi_mem_arbiter_if.slave        data_bus,
  obi_mem_arbiter_if.master       mem_bus,
  output logic                    err_o
);
  if (MAX_OUTST < 1) begin : g_bad_param
    $error("MAX_OUTST must be at least 1");
  end

  arb_id_e       last_q, lock_owner_q, owner, head_id;
  logic          lock_q, lock_d, err_q;
  logic          fifo_full, fifo_empty;
  logic          owner_req, lock_drop, m_req, accept, pop, spurious;
  logic [AW-1:0] addr_mux;
  logic [DW-1:0] wdata_mux;

  // Owner selection: a live lock forces the stored owner, otherwise round-robin.
  always_comb begin
    lock_drop = lock_q && !((lock_owner_q == ARB_INSTR) ? instr_bus.proc_req
                                                        : data_bus.proc_req);
    if (lock_q && !lock_drop) begin
      owner = lock_owner_q;
    end else begin
      owner = arb_pick(instr_bus.proc_req, data_bus.proc_req, last_q);
    end
    owner_req = (owner == ARB_INSTR) ? instr_bus.proc_req : data_bus.proc_req;
    // Full blocks requests; count is registered, so a same-cycle response cannot unblock.
    m_req     = owner_req && !fifo_full && !rst_i;
    accept    = m_req && mem_bus.mem_rdy;
    // A held lock persists (even while full) until accepted; a fresh lock
    // forms when a forwarded request is stalled.
    lock_d    = (lock_q && !lock_drop) ? !accept : (m_req && !mem_bus.mem_rdy);
  end

  assign addr_mux  = (owner == ARB_INSTR) ? instr_bus.addr  : data_bus.addr;
  assign wdata_mux = (owner == ARB_INSTR) ? instr_bus.wdata : data_bus.wdata;

  assign mem_bus.proc_req = m_req;
  assign mem_bus.addr     = addr_mux;
  assign mem_bus.we       = (owner == ARB_INSTR) ? instr_bus.we : data_bus.we;
  assign mem_bus.wdata    = wdata_mux;

  assign instr_bus.mem_rdy = accept && (owner == ARB_INSTR);
  assign data_bus.mem_rdy  = accept && (owner == ARB_DATA);

  // Response path: the FIFO head decides which port sees VALID.
  assign pop      = mem_bus.valid && !fifo_empty && !rst_i;
  assign spurious = mem_bus.valid && fifo_empty;

  assign instr_bus.valid = pop && (head_id == ARB_INSTR);
  assign data_bus.valid  = pop && (head_id == ARB_DATA);
  assign instr_bus.rdata = mem_bus.rdata;
  assign data_bus.rdata  = mem_bus.rdata;
  assign err_o           = err_q;

  arb_id_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (accept),
    .pop_i     (pop),
    .push_id_i (owner),
    .head_id_o (head_id),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Fairness history, lock state and sticky protocol error.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q       <= ARB_DATA;
      lock_q       <= 1'b0;
      lock_owner_q <= ARB_INSTR;
      err_q        <= 1'b0;
    end else begin
      if (accept) last_q <= owner;
      lock_q       <= lock_d;
      lock_owner_q <= owner;
      if (spurious || lock_drop) err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Directed, table-driven bench for obi_mem_arbiter with MAX_OUTST=2.
module tb_obi_mem_arbiter;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk;
  logic rst;
  logic err;

  obi_mem_arbiter_if #(.AW(32), .DW(32)) i_bus ();
  obi_mem_arbiter_if #(.AW(32), .DW(32)) d_bus ();
  obi_mem_arbiter_if #(.AW(32), .DW(32)) m_bus ();

  obi_mem_arbiter #(.MAX_OUTST(2), .AW(32), .DW(32)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .instr_bus (i_bus),
    .data_bus  (d_bus),
    .mem_bus   (m_bus),
    .err_o     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic [31:0] da;
    logic        dwe;
    logic [31:0] dwd;
    logic        mr;
    logic        mv;
    logic [31:0] mrd;
    logic        e_mreq;
    logic        chk_a;
    logic [31:0] e_maddr;
    logic        e_mwe;
    logic        e_irdy;
    logic        e_drdy;
    logic        e_iv;
    logic        e_dv;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic [31:0] da, input logic dwe, input logic [31:0] dwd,
                       input logic mr, input logic mv, input logic [31:0] mrd);
    i_bus.proc_req = ir;  i_bus.addr = ia; i_bus.we = 1'b0; i_bus.wdata = '0;
    d_bus.proc_req = dr;  d_bus.addr = da; d_bus.we = dwe;  d_bus.wdata = dwd;
    m_bus.mem_rdy  = mr;  m_bus.valid = mv; m_bus.rdata = mrd;
  endtask

  initial begin
    // ---------------- vector table ----------------
    // reset state, idle
    vecs.push_back('{L,32'h0,L,32'h0,L,32'h0,H,L,32'h0,          L,L,32'h0,L,L,L,L,L,L});
    // both requesting: I,D alternate from reset; responses routed in order
    vecs.push_back('{H,32'h100,H,32'h200,H,32'hDDDD0001,H,L,32'h0, H,H,32'h100,L,H,L,L,L,L});
    vecs.push_back('{H,32'h104,H,32'h200,H,32'hDDDD0001,H,L,32'h0, H,H,32'h200,H,L,H,L,L,L});
    vecs.push_back('{H,32'h104,H,32'h204,L,32'h0,H,H,32'h11110000, L,L,32'h0,L,L,L,H,L,L});
    vecs.push_back('{H,32'h104,H,32'h204,L,32'h0,H,H,32'hDDDD0001, H,H,32'h104,L,H,L,L,H,L});
    vecs.push_back('{L,32'h0,H,32'h204,L,32'h0,H,H,32'h11110004,   H,H,32'h204,L,L,H,H,L,L});
    vecs.push_back('{L,32'h0,L,32'h0,L,32'h0,H,H,32'h22220004,     L,L,32'h0,L,L,L,L,H,L});
    // D stalled three cycles; lock holds D although I would win on fairness
    vecs.push_back('{L,32'h0,H,32'h500,H,32'h55550000,L,L,32'h0,   H,H,32'h500,H,L,L,L,L,L});
    vecs.push_back('{H,32'h400,H,32'h500,H,32'h55550000,L,L,32'h0, H,H,32'h500,H,L,L,L,L,L});
    vecs.push_back('{H,32'h400,H,32'h500,H,32'h55550000,L,L,32'h0, H,H,32'h500,H,L,L,L,L,L});
    vecs.push_back('{H,32'h400,H,32'h500,H,32'h55550000,H,L,32'h0, H,H,32'h500,H,L,H,L,L,L});
    vecs.push_back('{H,32'h400,H,32'h504,L,32'h0,H,L,32'h0,        H,H,32'h400,L,H,L,L,L,L});
    // full: response in this cycle does not unblock; next cycle accepts
    vecs.push_back('{H,32'h404,H,32'h504,L,32'h0,H,H,32'h55550000, L,L,32'h0,L,L,L,L,H,L});
    vecs.push_back('{H,32'h404,H,32'h504,L,32'h0,H,H,32'h44440000, H,H,32'h504,L,L,H,H,L,L});
    vecs.push_back('{H,32'h404,L,32'h0,L,32'h0,H,H,32'h5555AAAA,   H,H,32'h404,L,H,L,L,H,L});
    vecs.push_back('{L,32'h0,L,32'h0,L,32'h0,H,H,32'h44440004,     L,L,32'h0,L,L,L,H,L,L});
    // fetch-only stream, latency 1
    vecs.push_back('{H,32'h300,L,32'h0,L,32'h0,H,L,32'h0,          H,H,32'h300,L,H,L,L,L,L});
    vecs.push_back('{H,32'h304,L,32'h0,L,32'h0,H,H,32'h33330000,   H,H,32'h304,L,H,L,H,L,L});
    vecs.push_back('{L,32'h0,L,32'h0,L,32'h0,H,H,32'h33330004,     L,L,32'h0,L,L,L,H,L,L});
    // spurious response with empty FIFO: no VALID, ERR sticky from next cycle
    vecs.push_back('{L,32'h0,L,32'h0,L,32'h0,H,H,32'hDEADBEEF,     L,L,32'h0,L,L,L,L,L,L});
    vecs.push_back('{L,32'h0,L,32'h0,L,32'h0,H,L,32'h0,            L,L,32'h0,L,L,L,L,L,H});
    vecs.push_back('{L,32'h0,L,32'h0,L,32'h0,H,L,32'h0,            L,L,32'h0,L,L,L,L,L,H});

    rst = 1'b1;
    drive(L, 0, L, 0, L, 0, L, L, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].ir, vecs[k].ia, vecs[k].dr, vecs[k].da, vecs[k].dwe, vecs[k].dwd,
            vecs[k].mr, vecs[k].mv, vecs[k].mrd);
      #2;
      chk($sformatf("v%0d m_req", k), 32'(m_bus.proc_req), 32'(vecs[k].e_mreq));
      if (vecs[k].chk_a) begin
        chk($sformatf("v%0d m_addr", k), m_bus.addr, vecs[k].e_maddr);
        chk($sformatf("v%0d m_we", k), 32'(m_bus.we), 32'(vecs[k].e_mwe));
        if (vecs[k].e_mwe) chk($sformatf("v%0d m_wdata", k), m_bus.wdata, vecs[k].dwd);
      end
      chk($sformatf("v%0d i_rdy", k), 32'(i_bus.mem_rdy), 32'(vecs[k].e_irdy));
      chk($sformatf("v%0d d_rdy", k), 32'(d_bus.mem_rdy), 32'(vecs[k].e_drdy));
      chk($sformatf("v%0d i_valid", k), 32'(i_bus.valid), 32'(vecs[k].e_iv));
      chk($sformatf("v%0d d_valid", k), 32'(d_bus.valid), 32'(vecs[k].e_dv));
      if (vecs[k].mv) begin
        chk($sformatf("v%0d i_rdata", k), i_bus.rdata, vecs[k].mrd);
        chk($sformatf("v%0d d_rdata", k), d_bus.rdata, vecs[k].mrd);
      end
      chk($sformatf("v%0d err", k), 32'(err), 32'(vecs[k].e_err));
      $display("vec %0d: m_req=%0b m_addr=%h i_rdy=%0b d_rdy=%0b i_v=%0b d_v=%0b err=%0b",
               k, m_bus.proc_req, m_bus.addr, i_bus.mem_rdy, d_bus.mem_rdy,
               i_bus.valid, d_bus.valid, err);
      @(posedge clk);
      #1;
    end

    // ---------------- reset with two outstanding ----------------
    // last grant before this is fetch, so D wins the contention here.
    drive(H, 32'h600, H, 32'h700, L, 0, H, L, 0);
    #2;
    chk("h0 d_rdy", 32'(d_bus.mem_rdy), 32'h1);
    chk("h0 m_addr", m_bus.addr, 32'h700);
    $display("seq h0: d_rdy=%0b m_addr=%h", d_bus.mem_rdy, m_bus.addr);
    @(posedge clk); #1;
    drive(H, 32'h600, L, 0, L, 0, H, L, 0);
    #2;
    chk("h1 i_rdy", 32'(i_bus.mem_rdy), 32'h1);
    $display("seq h1: i_rdy=%0b", i_bus.mem_rdy);
    @(posedge clk); #1;
    drive(H, 32'h604, H, 32'h704, L, 0, H, L, 0);
    #2;
    chk("h2 full m_req", 32'(m_bus.proc_req), 32'h0);
    chk("h2 err sticky", 32'(err), 32'h1);
    $display("seq h2: m_req=%0b err=%0b", m_bus.proc_req, err);
    // asynchronous reset mid-cycle, with a response and requests present
    drive(H, 32'h604, H, 32'h704, L, 0, H, H, 32'h12345678);
    rst = 1'b1;
    #1;
    chk("rst m_req", 32'(m_bus.proc_req), 32'h0);
    chk("rst i_rdy", 32'(i_bus.mem_rdy), 32'h0);
    chk("rst d_rdy", 32'(d_bus.mem_rdy), 32'h0);
    chk("rst i_valid", 32'(i_bus.valid), 32'h0);
    chk("rst d_valid", 32'(d_bus.valid), 32'h0);
    chk("rst err", 32'(err), 32'h0);
    $display("seq rst: m_req=%0b i_v=%0b d_v=%0b err=%0b",
             m_bus.proc_req, i_bus.valid, d_bus.valid, err);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(H, 32'h600, H, 32'h700, L, 0, H, L, 0);
    #2;
    chk("post-rst m_req", 32'(m_bus.proc_req), 32'h1);
    chk("post-rst m_addr", m_bus.addr, 32'h600);
    chk("post-rst i_rdy", 32'(i_bus.mem_rdy), 32'h1);
    chk("post-rst d_rdy", 32'(d_bus.mem_rdy), 32'h0);
    $display("seq p0: m_req=%0b m_addr=%h i_rdy=%0b", m_bus.proc_req, m_bus.addr, i_bus.mem_rdy);
    @(posedge clk); #1;
    drive(H, 32'h604, H, 32'h700, L, 0, H, L, 0);
    #2;
    chk("p1 d_rdy", 32'(d_bus.mem_rdy), 32'h1);
    chk("p1 m_addr", m_bus.addr, 32'h700);
    $display("seq p1: d_rdy=%0b m_addr=%h", d_bus.mem_rdy, m_bus.addr);
    @(posedge clk); #1;
    drive(H, 32'h604, H, 32'h704, L, 0, H, L, 0);
    #2;
    chk("p2 full m_req", 32'(m_bus.proc_req), 32'h0);
    chk("p2 full i_rdy", 32'(i_bus.mem_rdy), 32'h0);
    $display("seq p2: m_req=%0b", m_bus.proc_req);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/obi_mem_arbiter.md
# obi_mem_arbiter

Two-to-one arbiter sharing one single-port memory between the core's fetch port and LSU port. It uses the proc_req/mem_rdy/valid handshake of the core's memory interfaces. It sits between `riscv_core` and a unified `mem_wrap_fake` instance. Arbitration is round-robin with request locking. An in-order ID FIFO steers each response back to the requester that issued it.

## Interface
Parameters:
- MAX_OUTST, default 2: maximum accepted-but-unanswered transactions. Must be ≥1.
- AW, default 32: address width.
- DW, default 32: data width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset. Asynchronous and active-high.
- I_PROC_REQ / D_PROC_REQ  in  1  fetch / LSU request valid.
- I_MEM_RDY / D_MEM_RDY  out  1  request accepted this cycle.
- I_ADDR / D_ADDR  in  AW  request address.
- I_WE / D_WE  in  1  write enable.
- I_WDATA / D_WDATA  in  DW  write data.
- I_RDATA / D_RDATA  out  DW  response data.
- I_VALID / D_VALID  out  1  response valid.
- M_PROC_REQ  out  1  request to memory.
- M_MEM_RDY  in  1  memory accepts the request.
- M_ADDR  out  AW  muxed address.
- M_WE  out  1  muxed write enable.
- M_WDATA  out  DW  muxed write data.
- M_RDATA  in  DW  memory response data.
- M_VALID  in  1  memory response valid.
- ERR  out  1  sticky protocol error.

## Operation
- Accept on a port means PROC_REQ && MEM_RDY in the same cycle. A requester holds PROC_REQ, ADDR, WE and WDATA stable until accepted.
- `full` = outstanding count == MAX_OUTST.
- While full: M_PROC_REQ=0 and both MEM_RDY=0. A response arriving in the same cycle does not unblock that cycle.
- Grant owner when not locked:
  - Only one requester active: that requester wins.
  - Both active: the requester not in `last_q` wins.
  - None active: M_PROC_REQ=0. Mux selects fetch. Address/data outputs are don't-care.
- Lock: if M_PROC_REQ=1 and M_MEM_RDY=0, set lock_q and store the owner. The owner is forced on following cycles until accepted.
- Lock is cleared on accept. Lock is also cleared if the locked requester drops PROC_REQ; this is a protocol violation and sets ERR.
- M_PROC_REQ = owner's PROC_REQ && !full. M_ADDR, M_WE and M_WDATA come from the owner.
- Owner's MEM_RDY = M_MEM_RDY && M_PROC_REQ. Non-owner MEM_RDY=0.
- On a memory accept:
  - Push owner ID onto the ID FIFO.
  - last_q ← owner.
- On M_VALID:
  - Pop the FIFO head.
  - Head == INSTR → I_VALID=1. Head == DATA → D_VALID=1.
  - I_RDATA = D_RDATA = M_RDATA always.
- Push and pop in the same cycle: count unchanged; head advances.
- M_VALID with FIFO empty: no VALID to either port; ERR←1; count stays 0.
- ERR clears only on RST.
- Responses have no back-pressure. Requesters must always sink VALID.

## Timing
- Arbitration and request path are combinational, zero added latency: PROC_REQ→M_PROC_REQ and M_MEM_RDY→MEM_RDY.
- Response routing is combinational, zero added latency: M_VALID→I_VALID/D_VALID.
- Registered state: last_q, lock_q, lock owner, FIFO pointers, count, ERR.
- Register reset values: last_q=DATA, so fetch wins the first contention. lock_q=0, count=0, ERR=0.
- Output values while RST is high:
  - M_PROC_REQ=0, I_MEM_RDY=0, D_MEM_RDY=0.
  - I_VALID=0, D_VALID=0.
  - ERR=0.
- Reset mid-transaction: outstanding IDs are discarded. The memory shares RST, so no late responses are expected. Any late response sets ERR.
- No combinational path from M_VALID to M_PROC_REQ or to either MEM_RDY.

## Structure
- riscv_pkg gains `arb_id_e` (ARB_INSTR=1'b0, ARB_DATA=1'b1).
- Sub-module `arb_id_fifo`:
  - Parameters: DEPTH=MAX_OUTST, element type arb_id_e.
  - Ports: push, pop, push_id, head_id, full, empty.
  - Count width $clog2(DEPTH+1).
  - Pointers wrap modulo DEPTH; DEPTH need not be a power of two.
- Top level holds the grant/lock logic and muxing.

## Test plan
- Fetch-only stream, M_MEM_RDY=1, memory latency 1:
  - Each request is forwarded the same cycle.
  - I_VALID follows each response; D_VALID never asserts.
- Both request continuously, MAX_OUTST=2, memory accepts every cycle:
  - Grants alternate I,D,I,D starting with I.
  - Responses are routed in the same order; D_RDATA matches the data written.
- D owner stalled by M_MEM_RDY=0 for 3 cycles while I requests:
  - D stays owner, with M_ADDR stable at D_ADDR.
  - After D is accepted, I wins the next cycle.
- Full condition with MAX_OUTST=2 and two accepted requests unanswered:
  - M_PROC_REQ=0 and both MEM_RDY=0.
  - A response arriving in that cycle gives a new accept only in the following cycle.
- Spurious M_VALID with FIFO empty: no port VALID, ERR=1. ERR stays set until RST.
- RST asserted with 2 outstanding:
  - Outputs return to reset values asynchronously.
  - After release, the first contention is granted to fetch.
